// File: rtl/id_branch_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_branch_hazard_unit: IF/ID register, ID-stage BEQ/BNE/J resolution,     |
// | load-use / branch-operand hazard detection and saturating perf counters.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module id_branch_hazard_unit #(
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pcp4,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pcp4,
  output logic             id_valid,
  output logic             br_taken,
  output logic [31:0]      br_addr,
  output logic             freeze,
  output logic             id_bubble,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0]       c_OP_RTYPE = 6'h00;
  localparam logic [5:0]       c_OP_J     = 6'h02;
  localparam logic [5:0]       c_OP_BEQ   = 6'h04;
  localparam logic [5:0]       c_OP_BNE   = 6'h05;
  localparam logic [5:0]       c_OP_SW    = 6'h2B;
  localparam logic             c_FLUSH    = (DELAY_SLOT == 0);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_instr;
  logic [31:0]      r_pcp4;
  logic             r_valid;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [15:0] w_imm;
  logic [25:0] w_tgt;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic        w_is_br;
  logic        w_ex_rs;
  logic        w_ex_rt;
  logic        w_mem_rs;
  logic        w_mem_rt;
  logic        w_load_use;
  logic        w_br_on_alu;
  logic        w_br_on_load;
  logic        w_freeze;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_br_off;
  logic [31:0] w_br_addr;

  assign w_op  = r_instr[31:26];
  assign w_rs  = r_instr[25:21];
  assign w_rt  = r_instr[20:16];
  assign w_imm = r_instr[15:0];
  assign w_tgt = r_instr[25:0];

  assign w_uses_rs = (w_op != c_OP_J);
  assign w_uses_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                     (w_op == c_OP_BNE)   || (w_op == c_OP_SW);
  assign w_is_br   = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);

  // $0 is hardwired, so a match on register 0 is never a real dependency
  assign w_ex_rs  = (w_rs != 5'd0) && (w_rs == ex_dest);
  assign w_ex_rt  = (w_rt != 5'd0) && (w_rt == ex_dest);
  assign w_mem_rs = (w_rs != 5'd0) && (w_rs == mem_dest);
  assign w_mem_rt = (w_rt != 5'd0) && (w_rt == mem_dest);

  assign w_load_use   = ex_mem_read && ((w_uses_rs && w_ex_rs) || (w_uses_rt && w_ex_rt));
  assign w_br_on_alu  = w_is_br && ex_reg_write && (w_ex_rs || w_ex_rt);
  assign w_br_on_load = w_is_br && mem_mem_read && (w_mem_rs || w_mem_rt);
  assign w_freeze     = r_valid && (w_load_use || w_br_on_alu || w_br_on_load);

  assign w_cond  = ((w_op == c_OP_BEQ) && (rs_val == rt_val)) ||
                   ((w_op == c_OP_BNE) && (rs_val != rt_val)) ||
                   (w_op == c_OP_J);
  assign w_taken = r_valid && w_cond && !w_freeze;

  assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};

  always_comb begin
    w_br_addr = 32'd0;
    if (w_is_br) begin
      w_br_addr = r_pcp4 + w_br_off;
    end else if (w_op == c_OP_J) begin
      w_br_addr = {r_pcp4[31:28], w_tgt, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= 32'd0;
      r_pcp4  <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_freeze) begin
      r_instr <= r_instr;
      r_pcp4  <= r_pcp4;
      r_valid <= r_valid;
    end else if (w_taken && c_FLUSH) begin
      r_instr <= 32'd0;
      r_pcp4  <= if_pcp4;
      r_valid <= 1'b0;
    end else begin
      r_instr <= if_instr;
      r_pcp4  <= if_pcp4;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_taken && !(&r_br_cnt)) begin
        r_br_cnt <= r_br_cnt + c_CNT_ONE;
      end
      if (w_freeze && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
    end
  end

  assign id_instr  = r_instr;
  assign id_pcp4   = r_pcp4;
  assign id_valid  = r_valid;
  assign br_taken  = w_taken;
  assign br_addr   = w_br_addr;
  assign freeze    = w_freeze;
  assign id_bubble = w_freeze;
  assign br_cnt    = r_br_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_branch_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_branch_hazard_unit: directed + random checks of two instances        |
// | (no delay slot / 32-bit counters, delay slot / 4-bit counters).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_id_branch_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pcp4, if_instr, rs_val, rt_val;
  logic        ex_mem_read, ex_reg_write, mem_mem_read;
  logic [4:0]  ex_dest, mem_dest;

  logic [31:0] d0_instr, d0_pcp4, d0_addr, d0_br, d0_st;
  logic        d0_valid, d0_taken, d0_frz, d0_bub;
  logic [31:0] d1_instr, d1_pcp4, d1_addr;
  logic [3:0]  d1_br, d1_st;
  logic        d1_valid, d1_taken, d1_frz, d1_bub;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_instr [2];
  logic [31:0] m_pcp4  [2];
  logic        m_valid [2];
  logic [31:0] m_br    [2];
  logic [31:0] m_st    [2];
  logic [31:0] m_max   [2];
  logic        m_ds    [2];

  id_branch_hazard_unit #(.DELAY_SLOT(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .if_pcp4(if_pcp4), .if_instr(if_instr),
    .rs_val(rs_val), .rt_val(rt_val), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .id_instr(d0_instr), .id_pcp4(d0_pcp4), .id_valid(d0_valid),
    .br_taken(d0_taken), .br_addr(d0_addr), .freeze(d0_frz), .id_bubble(d0_bub),
    .br_cnt(d0_br), .stall_cnt(d0_st)
  );

  id_branch_hazard_unit #(.DELAY_SLOT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .if_pcp4(if_pcp4), .if_instr(if_instr),
    .rs_val(rs_val), .rt_val(rt_val), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dest(ex_dest), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .id_instr(d1_instr), .id_pcp4(d1_pcp4), .id_valid(d1_valid),
    .br_taken(d1_taken), .br_addr(d1_addr), .freeze(d1_frz), .id_bubble(d1_bub),
    .br_cnt(d1_br), .stall_cnt(d1_st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic hits(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  task automatic predict(input int k, output logic frz, output logic tkn, output logic [31:0] addr);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic use_rs, use_rt, br, lu, bx, bm, cond;
    int off;
    op     = m_instr[k][31:26];
    rs     = m_instr[k][25:21];
    rt     = m_instr[k][20:16];
    use_rs = (op != 6'h02);
    use_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    br     = (op == 6'h04) || (op == 6'h05);
    lu     = ex_mem_read && ((use_rs && hits(rs, ex_dest)) || (use_rt && hits(rt, ex_dest)));
    bx     = br && ex_reg_write && (hits(rs, ex_dest) || hits(rt, ex_dest));
    bm     = br && mem_mem_read && (hits(rs, mem_dest) || hits(rt, mem_dest));
    frz    = m_valid[k] && (lu || bx || bm);
    cond   = ((op == 6'h04) && (rs_val == rt_val)) || ((op == 6'h05) && (rs_val != rt_val)) ||
             (op == 6'h02);
    tkn    = m_valid[k] && cond && !frz;
    off    = int'($signed(m_instr[k][15:0]));
    if (br) addr = m_pcp4[k] + 32'(off * 4);
    else if (op == 6'h02) addr = (m_pcp4[k] & 32'hF000_0000) + {4'h0, m_instr[k][25:0], 2'b00};
    else addr = 32'd0;
  endtask

  task automatic check_one(input int k, input logic [31:0] instr, input logic [31:0] pcp4,
                           input logic valid, input logic taken, input logic [31:0] addr,
                           input logic frz, input logic bub, input logic [31:0] brc,
                           input logic [31:0] stc);
    logic e_frz, e_tkn;
    logic [31:0] e_addr;
    string p;
    p = (k == 0) ? "d0" : "d1";
    predict(k, e_frz, e_tkn, e_addr);
    chk({p, ".id_instr"}, instr, m_instr[k]);
    chk({p, ".id_pcp4"}, pcp4, m_pcp4[k]);
    chk({p, ".id_valid"}, {31'd0, valid}, {31'd0, m_valid[k]});
    chk({p, ".br_taken"}, {31'd0, taken}, {31'd0, e_tkn});
    chk({p, ".br_addr"}, addr, e_addr);
    chk({p, ".freeze"}, {31'd0, frz}, {31'd0, e_frz});
    chk({p, ".id_bubble"}, {31'd0, bub}, {31'd0, e_frz});
    chk({p, ".br_cnt"}, brc, m_br[k]);
    chk({p, ".stall_cnt"}, stc, m_st[k]);
  endtask

  task automatic check_all();
    check_one(0, d0_instr, d0_pcp4, d0_valid, d0_taken, d0_addr, d0_frz, d0_bub, d0_br, d0_st);
    check_one(1, d1_instr, d1_pcp4, d1_valid, d1_taken, d1_addr, d1_frz, d1_bub,
              {28'd0, d1_br}, {28'd0, d1_st});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_instr[k] = 32'd0; m_pcp4[k] = 32'd0; m_valid[k] = 1'b0;
      m_br[k] = 32'd0; m_st[k] = 32'd0;
    end
  endtask

  // Check current outputs, clock once, then advance the reference state.
  task automatic step();
    logic f, t;
    logic [31:0] a;
    logic [31:0] n_instr [2];
    logic [31:0] n_pcp4 [2];
    logic        n_valid [2];
    logic [31:0] n_br [2];
    logic [31:0] n_st [2];
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      predict(k, f, t, a);
      n_br[k] = (t && m_br[k] != m_max[k]) ? m_br[k] + 1 : m_br[k];
      n_st[k] = (f && m_st[k] != m_max[k]) ? m_st[k] + 1 : m_st[k];
      if (f) begin
        n_instr[k] = m_instr[k]; n_pcp4[k] = m_pcp4[k]; n_valid[k] = m_valid[k];
      end else if (t && !m_ds[k]) begin
        n_instr[k] = 32'd0; n_pcp4[k] = if_pcp4; n_valid[k] = 1'b0;
      end else begin
        n_instr[k] = if_instr; n_pcp4[k] = if_pcp4; n_valid[k] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_instr[k] = n_instr[k]; m_pcp4[k] = n_pcp4[k]; m_valid[k] = n_valid[k];
      m_br[k] = n_br[k]; m_st[k] = n_st[k];
    end
  endtask

  task automatic rand_inputs();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00; 1: op = 6'h04; 2: op = 6'h05; 3: op = 6'h02;
      4: op = 6'h23; 5: op = 6'h2B; default: op = 6'h08;
    endcase
    if_instr     = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    if_pcp4      = 32'($urandom) & 32'hFFFF_FFFC;
    rs_val       = 32'($urandom_range(0, 3));
    rt_val       = 32'($urandom_range(0, 3));
    ex_mem_read  = ($urandom_range(0, 3) == 0);
    ex_reg_write = 1'($urandom_range(0, 1));
    ex_dest      = 5'($urandom_range(0, 7));
    mem_mem_read = ($urandom_range(0, 3) == 0);
    mem_dest     = 5'($urandom_range(0, 7));
  endtask

  task automatic quiet(input logic [31:0] instr, input logic [31:0] pcp4);
    if_instr = instr; if_pcp4 = pcp4;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
    mem_mem_read = 1'b0; mem_dest = 5'd0;
  endtask

  localparam logic [31:0] c_ADD  = 32'h0022_1820;   // add $3,$1,$2
  localparam logic [31:0] c_ADD5 = 32'h00A7_3020;   // add $6,$5,$7

  initial begin
    m_max[0] = 32'hFFFF_FFFF; m_max[1] = 32'd15;
    m_ds[0]  = 1'b0;          m_ds[1]  = 1'b1;
    model_reset();

    // Reset with garbage inputs
    rst = 1'b0;
    rand_inputs();
    ex_mem_read = 1'b1; ex_dest = 5'd3; if_instr = 32'h1062_0003;
    #2;
    check_all();
    chk("rst.freeze", {31'd0, d0_frz}, 32'd0);
    chk("rst.br_addr", d0_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ADD loads into ID
    quiet(c_ADD, 32'd4); rs_val = 32'd0; rt_val = 32'd0;
    step();
    chk("t1.id_valid", {31'd0, d0_valid}, 32'd1);
    chk("t1.id_pcp4", d0_pcp4, 32'd4);

    // BEQ $1,$2,+3 taken
    quiet({6'h04, 5'd1, 5'd2, 16'd3}, 32'h10);
    step();
    quiet(32'd0, 32'h14); rs_val = 32'd7; rt_val = 32'd7;
    #1;
    chk("t2.br_taken", {31'd0, d0_taken}, 32'd1);
    chk("t2.br_addr", d0_addr, 32'h1C);
    step();
    chk("t2.flush_valid", {31'd0, d0_valid}, 32'd0);
    chk("t2.br_cnt", d0_br, 32'd1);

    // BNE with negative offset, then J
    quiet({6'h05, 5'd1, 5'd2, 16'hFFFE}, 32'h8);
    step();
    quiet(32'd0, 32'hC); rs_val = 32'd1; rt_val = 32'd2;
    #1;
    chk("t3.bne_addr", d0_addr, 32'h0);
    chk("t3.bne_taken", {31'd0, d0_taken}, 32'd1);
    step();
    quiet({6'h02, 26'h40}, 32'hF000_0004);
    step();
    quiet(32'd0, 32'hF000_0008);
    #1;
    chk("t3.j_addr", d0_addr, 32'hF000_0100);
    step();

    // Load-use stall
    quiet(c_ADD5, 32'h20);
    step();
    quiet(c_ADD, 32'h24); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5;
    #1;
    chk("t4.freeze", {31'd0, d0_frz}, 32'd1);
    chk("t4.bubble", {31'd0, d0_bub}, 32'd1);
    step();
    chk("t4.held", d0_instr, c_ADD5);
    chk("t4.stall_cnt", d0_st, 32'd1);
    quiet(32'd0, 32'h24); mem_mem_read = 1'b1; mem_dest = 5'd5;
    #1;
    chk("t4.unfreeze", {31'd0, d0_frz}, 32'd0);
    step();

    // BEQ $5,$0 behind LW $5: two freeze cycles, then resolve
    quiet({6'h04, 5'd5, 5'd0, 16'd2}, 32'h40);
    step();
    quiet(32'd0, 32'h44); rs_val = 32'd0; rt_val = 32'd0;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5;
    #1;
    chk("t5.frz_ex", {31'd0, d0_frz}, 32'd1);
    chk("t5.tkn_ex", {31'd0, d0_taken}, 32'd0);
    step();
    quiet(32'd0, 32'h44); mem_mem_read = 1'b1; mem_dest = 5'd5;
    #1;
    chk("t5.frz_mem", {31'd0, d0_frz}, 32'd1);
    chk("t5.tkn_mem", {31'd0, d0_taken}, 32'd0);
    step();
    quiet(32'd0, 32'h44);
    #1;
    chk("t5.resolve", {31'd0, d0_taken}, 32'd1);
    chk("t5.addr", d0_addr, 32'h48);
    step();
    chk("t5.stall_cnt", d0_st, 32'd3);
    chk("t5.br_cnt", d0_br, 32'd4);

    // Delay slot keeps the following instruction
    quiet({6'h04, 5'd1, 5'd2, 16'd1}, 32'h50);
    step();
    quiet(c_ADD, 32'h54); rs_val = 32'd1; rt_val = 32'd1;
    step();
    chk("t6.ds_valid", {31'd0, d1_valid}, 32'd1);
    chk("t6.ds_instr", d1_instr, c_ADD);
    chk("t6.nods_valid", {31'd0, d0_valid}, 32'd0);

    // Reset asserted during a freeze
    quiet(c_ADD5, 32'h60);
    step();
    quiet(32'd0, 32'h64); ex_mem_read = 1'b1; ex_dest = 5'd5;
    #1;
    chk("t6.pre_frz", {31'd0, d1_frz}, 32'd1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6.rst_frz0", {31'd0, d0_frz}, 32'd0);
    chk("t6.rst_frz1", {31'd0, d1_frz}, 32'd0);
    chk("t6.rst_st", d0_st, 32'd0);
    chk("t6.rst_br", d0_br, 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        rand_inputs();
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
